// File: rtl/serial_uart_bridge.sv
// 8N1 UART bridge: an RX deserializer feeding a show-ahead byte FIFO, and a TX byte FIFO
// draining into a serializer. Single clock, synchronous active-high reset.
module serial_uart_bridge #(
  parameter int CLKS_PER_BIT  = 16,
  parameter int TX_FIFO_DEPTH = 4,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx_in,
  output logic       uart_tx_out,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  input  logic       rx_rden_in,
  input  logic [7:0] tx_data_in,
  input  logic       tx_wren_in,
  output logic       tx_ready_out,
  output logic       tx_busy_out,
  output logic       rx_overrun_out,
  output logic       rx_frame_err_out
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int TAW = $clog2(TX_FIFO_DEPTH);
  localparam int RAW = $clog2(RX_FIFO_DEPTH);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TAW:0]   TX_FULL   = (TAW + 1)'(TX_FIFO_DEPTH);
  localparam logic [RAW:0]   RX_FULL   = (RAW + 1)'(RX_FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // TX side
  logic [7:0]    tx_mem_r [TX_FIFO_DEPTH];
  logic [TAW-1:0] tx_wr_ptr_r, tx_rd_ptr_r;
  logic [TAW:0]  tx_count_r;
  logic          tx_full_s, tx_push_s, tx_pop_s;
  state_t        tx_state_r;
  logic [CW-1:0] tx_timer_r;
  logic [2:0]    tx_bit_r;
  logic [7:0]    tx_shift_r;
  logic          tx_line_r, tx_busy_r;

  // RX side
  logic          rx_sync1_r, rx_sync2_r, rx_prev_r;
  logic          rx_fall_s;
  state_t        rx_state_r;
  logic [CW-1:0] rx_timer_r;
  logic [2:0]    rx_bit_r;
  logic [7:0]    rx_shift_r;
  logic          rx_push_r;
  logic [7:0]    rx_byte_r;
  logic          rx_frame_err_r, rx_overrun_r;
  logic [7:0]    rx_mem_r [RX_FIFO_DEPTH];
  logic [RAW-1:0] rx_wr_ptr_r, rx_rd_ptr_r;
  logic [RAW:0]  rx_count_r;
  logic          rx_full_s, rx_pop_s, rx_push_ok_s;

  assign tx_full_s = (tx_count_r == TX_FULL);
  assign tx_push_s = tx_wren_in && !tx_full_s;
  assign tx_pop_s  = (tx_state_r == S_IDLE) && (tx_count_r != '0);

  // TX FIFO storage, pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wr_ptr_r <= '0;
      tx_rd_ptr_r <= '0;
      tx_count_r  <= '0;
    end else begin
      if (tx_push_s) begin
        tx_mem_r[tx_wr_ptr_r] <= tx_data_in;
        tx_wr_ptr_r <= tx_wr_ptr_r + TAW'(1);
      end
      if (tx_pop_s) begin
        tx_rd_ptr_r <= tx_rd_ptr_r + TAW'(1);
      end
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_count_r <= tx_count_r + (TAW + 1)'(1);
        2'b01:   tx_count_r <= tx_count_r - (TAW + 1)'(1);
        default: tx_count_r <= tx_count_r;
      endcase
    end
  end

  // TX serializer FSM; the FIFO head moves into the shift register on leaving IDLE
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_r <= S_IDLE;
      tx_timer_r <= '0;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'h00;
    end else begin
      case (tx_state_r)
        S_IDLE: begin
          tx_timer_r <= '0;
          tx_bit_r   <= 3'd0;
          if (tx_pop_s) begin
            tx_shift_r <= tx_mem_r[tx_rd_ptr_r];
            tx_state_r <= S_START;
          end
        end
        S_START: begin
          if (tx_timer_r == BIT_LAST) begin
            tx_timer_r <= '0;
            tx_state_r <= S_DATA;
          end else begin
            tx_timer_r <= tx_timer_r + CW'(1);
          end
        end
        S_DATA: begin
          if (tx_timer_r == BIT_LAST) begin
            tx_timer_r <= '0;
            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
            tx_bit_r   <= tx_bit_r + 3'd1;
            if (tx_bit_r == 3'd7) begin
              tx_state_r <= S_STOP;
            end
          end else begin
            tx_timer_r <= tx_timer_r + CW'(1);
          end
        end
        S_STOP: begin
          if (tx_timer_r == BIT_LAST) begin
            tx_timer_r <= '0;
            tx_state_r <= S_IDLE;
          end else begin
            tx_timer_r <= tx_timer_r + CW'(1);
          end
        end
        default: tx_state_r <= S_IDLE;
      endcase
    end
  end

  // Line and busy are registered from the state, so both lag it by one cycle and stay aligned
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_line_r <= 1'b1;
      tx_busy_r <= 1'b0;
    end else begin
      tx_busy_r <= (tx_state_r != S_IDLE);
      case (tx_state_r)
        S_START: tx_line_r <= 1'b0;
        S_DATA:  tx_line_r <= tx_shift_r[0];
        default: tx_line_r <= 1'b1;
      endcase
    end
  end

  // Two-flop synchronizer plus previous-value flop for falling-edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_sync1_r <= 1'b1;
      rx_sync2_r <= 1'b1;
      rx_prev_r  <= 1'b1;
    end else begin
      rx_sync1_r <= uart_rx_in;
      rx_sync2_r <= rx_sync1_r;
      rx_prev_r  <= rx_sync2_r;
    end
  end

  assign rx_fall_s = rx_prev_r && !rx_sync2_r;

  // RX deserializer FSM; a low line after a bad stop bit needs a fresh high-to-low edge
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_r     <= S_IDLE;
      rx_timer_r     <= '0;
      rx_bit_r       <= 3'd0;
      rx_shift_r     <= 8'h00;
      rx_push_r      <= 1'b0;
      rx_byte_r      <= 8'h00;
      rx_frame_err_r <= 1'b0;
    end else begin
      rx_push_r <= 1'b0;
      case (rx_state_r)
        S_IDLE: begin
          rx_timer_r <= '0;
          rx_bit_r   <= 3'd0;
          if (rx_fall_s) begin
            rx_state_r <= S_START;
          end
        end
        S_START: begin
          if (rx_timer_r == HALF_LAST) begin
            rx_timer_r <= '0;
            rx_state_r <= rx_sync2_r ? S_IDLE : S_DATA;
          end else begin
            rx_timer_r <= rx_timer_r + CW'(1);
          end
        end
        S_DATA: begin
          if (rx_timer_r == BIT_LAST) begin
            rx_timer_r <= '0;
            rx_shift_r <= {rx_sync2_r, rx_shift_r[7:1]};
            rx_bit_r   <= rx_bit_r + 3'd1;
            if (rx_bit_r == 3'd7) begin
              rx_state_r <= S_STOP;
            end
          end else begin
            rx_timer_r <= rx_timer_r + CW'(1);
          end
        end
        S_STOP: begin
          if (rx_timer_r == BIT_LAST) begin
            rx_timer_r <= '0;
            rx_state_r <= S_IDLE;
            if (rx_sync2_r) begin
              rx_push_r <= 1'b1;
              rx_byte_r <= rx_shift_r;
            end else begin
              rx_frame_err_r <= 1'b1;
            end
          end else begin
            rx_timer_r <= rx_timer_r + CW'(1);
          end
        end
        default: rx_state_r <= S_IDLE;
      endcase
    end
  end

  assign rx_full_s    = (rx_count_r == RX_FULL);
  assign rx_pop_s     = rx_rden_in && (rx_count_r != '0);
  assign rx_push_ok_s = rx_push_r && (!rx_full_s || rx_pop_s);

  // RX FIFO storage, pointers, occupancy and sticky overrun
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_wr_ptr_r  <= '0;
      rx_rd_ptr_r  <= '0;
      rx_count_r   <= '0;
      rx_overrun_r <= 1'b0;
    end else begin
      if (rx_push_ok_s) begin
        rx_mem_r[rx_wr_ptr_r] <= rx_byte_r;
        rx_wr_ptr_r <= rx_wr_ptr_r + RAW'(1);
      end
      if (rx_pop_s) begin
        rx_rd_ptr_r <= rx_rd_ptr_r + RAW'(1);
      end
      if (rx_push_r && !rx_push_ok_s) begin
        rx_overrun_r <= 1'b1;
      end
      case ({rx_push_ok_s, rx_pop_s})
        2'b10:   rx_count_r <= rx_count_r + (RAW + 1)'(1);
        2'b01:   rx_count_r <= rx_count_r - (RAW + 1)'(1);
        default: rx_count_r <= rx_count_r;
      endcase
    end
  end

  assign uart_tx_out      = tx_line_r;
  assign tx_busy_out      = tx_busy_r;
  assign tx_ready_out     = !tx_full_s;
  assign rx_valid_out     = (rx_count_r != '0);
  assign rx_data_out      = rx_valid_out ? rx_mem_r[rx_rd_ptr_r] : 8'h00;
  assign rx_overrun_out   = rx_overrun_r;
  assign rx_frame_err_out = rx_frame_err_r;

endmodule
